// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_seq
// Description : Multicycle 4-byte instruction fetch feeding instr_reg.
//               Optional per-byte wait timeout under `FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_seq #(
    parameter int            AW             = 8,
    parameter logic [AW-1:0] RESET_PC       = '0,
    parameter int            TIMEOUT_CYCLES = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          fetch_start_i,
    input  logic          pc_load_i,
    input  logic [AW-1:0] pc_next_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    input  logic [7:0]    mem_rdata_i,
    input  logic          mem_ready_i,
    output logic [7:0]    instr8bit_o,
    output logic [3:0]    IRWrite_o,
    output logic          fetch_en_o,
    output logic          fetch_done_o,
    output logic          fetch_err_o,
    output logic          busy_o,
    output logic [AW-1:0] pc_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RD3  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_pc;
    logic [7:0]    r_instr8;
    logic [3:0]    r_irwrite;
    logic          r_done;
    logic          r_err;
    logic          w_rd;
    logic [2:0]    w_idx;
    logic [1:0]    w_lane;
    logic          w_accept;
    logic          w_start;
    logic          w_timeout;

    assign w_rd     = (r_state == S_RD0) || (r_state == S_RD1) ||
                      (r_state == S_RD2) || (r_state == S_RD3);
    // RDk encodings are consecutive, so the byte lane is the state offset from RD0
    assign w_idx    = 3'(r_state) - 3'd1;
    assign w_lane   = w_idx[1:0];
    assign w_accept = w_rd && mem_ready_i;
    assign w_start  = (r_state == S_IDLE) && !pc_load_i && fetch_start_i;

`ifdef FETCH_TIMEOUT_EN
    localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_wait_w-1:0] r_wait;

    always_ff @(posedge clk_i) begin
        if (rst_i || !w_rd || w_accept || w_timeout) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign w_timeout = w_rd && !mem_ready_i &&
                       (r_wait == c_wait_w'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)  w_state_nxt = S_RD0;
            S_RD0:   if (w_accept) w_state_nxt = S_RD1;
            S_RD1:   if (w_accept) w_state_nxt = S_RD2;
            S_RD2:   if (w_accept) w_state_nxt = S_RD3;
            S_RD3:   if (w_accept) w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base    <= '0;
            r_pc      <= RESET_PC;
            r_instr8  <= 8'h00;
            r_irwrite <= 4'b0000;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_irwrite <= w_accept ? (4'b0001 << w_lane) : 4'b0000;
            if (w_accept) begin
                r_instr8 <= mem_rdata_i;
            end
            r_done <= (r_state == S_WB);
            r_err  <= w_timeout;
            if (w_start) begin
                r_base <= r_pc;
            end
            if ((r_state == S_IDLE) && pc_load_i) begin
                r_pc <= pc_next_i;
            end else if (r_state == S_WB) begin
                r_pc <= r_base + AW'(4);
            end
        end
    end

    assign mem_rd_o     = w_rd;
    assign mem_addr_o   = w_rd ? (r_base + AW'(w_lane)) : '0;
    assign instr8bit_o  = r_instr8;
    assign IRWrite_o    = r_irwrite;
    assign fetch_en_o   = |r_irwrite;
    assign fetch_done_o = r_done;
    assign fetch_err_o  = r_err;
    assign busy_o       = (r_state != S_IDLE);
    assign pc_o         = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_seq
// Description : Directed bench for instr_fetch_seq with a transaction-level
//               reference model and per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_seq;

    localparam int         AW             = 8;
    localparam logic [7:0] RESET_PC       = 8'h00;
    localparam int         TIMEOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pc_load;
    logic [7:0] pc_next;
    logic       ready;
    wire  [7:0] mem_addr;
    wire        mem_rd;
    wire  [7:0] mem_rdata;
    wire  [7:0] instr8;
    wire  [3:0] irwrite;
    wire        fetch_en;
    wire        done;
    wire        err;
    wire        busy;
    wire  [7:0] pc;

    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    instr_fetch_seq #(
        .AW             (AW),
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_start_i (start),
        .pc_load_i     (pc_load),
        .pc_next_i     (pc_next),
        .mem_addr_o    (mem_addr),
        .mem_rd_o      (mem_rd),
        .mem_rdata_i   (mem_rdata),
        .mem_ready_i   (ready),
        .instr8bit_o   (instr8),
        .IRWrite_o     (irwrite),
        .fetch_en_o    (fetch_en),
        .fetch_done_o  (done),
        .fetch_err_o   (err),
        .busy_o        (busy),
        .pc_o          (pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch is "bytes accepted so far" plus a write-back step
    bit         m_valid  = 1'b0;
    bit         m_active = 1'b0;
    int         m_got    = 0;
    int         m_wait   = 0;
    logic [7:0] m_base   = 8'h00;
    logic [7:0] m_pc     = 8'h00;
    logic [7:0] m_byte   = 8'h00;
    logic [3:0] m_strobe = 4'h0;
    bit         m_done   = 1'b0;
    bit         m_err    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_got    = 0;
            m_wait   = 0;
            m_pc     = RESET_PC;
            m_byte   = 8'h00;
            m_strobe = 4'h0;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_strobe = 4'h0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            if (!m_active) begin
                if (pc_load) begin
                    m_pc = pc_next;
                end else if (start) begin
                    m_active = 1'b1;
                    m_base   = m_pc;
                    m_got    = 0;
                    m_wait   = 0;
                end
            end else if (m_got < 4) begin
                if (ready) begin
                    m_strobe = 4'(1 << m_got);
                    m_byte   = mem[8'(m_base + m_got)];
                    m_got++;
                    m_wait = 0;
                end else begin
                    m_wait++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_wait == TIMEOUT_CYCLES) begin
                        m_active = 1'b0;
                        m_err    = 1'b1;
                    end
`endif
                end
            end else begin
                m_active = 1'b0;
                m_pc     = 8'(m_base + 4);
                m_done   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",      busy,     m_active);
            chk("mem_rd",    mem_rd,   m_active && (m_got < 4));
            chk("mem_addr",  mem_addr, (m_active && (m_got < 4)) ? 8'(m_base + m_got) : 8'h00);
            chk("IRWrite",   irwrite,  m_strobe);
            chk("fetch_en",  fetch_en, m_strobe != 4'h0);
            chk("instr8bit", instr8,   m_byte);
            chk("done",      done,     m_done);
            chk("err",       err,      m_err);
            chk("pc",        pc,       m_pc);
        end
    end

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h00] = 8'h56;
        mem[8'h01] = 8'h34;
        mem[8'h02] = 8'h12;
        mem[8'h03] = 8'hAB;
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        rst = 1'b1; start = 1'b0; pc_load = 1'b0; pc_next = 8'h00; ready = 1'b1;

        go(2);
        chk("rst_pc", pc, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_irwrite", irwrite, 0);
        chk("rst_mem_rd", mem_rd, 0);
        rst = 1'b0;

        // zero-wait fetch, then a back-to-back fetch started in the done cycle
        start = 1'b1; go(1); start = 1'b0;
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_addr", mem_addr, 8'h00);
        go(1);
        chk("t1_c2_irw", irwrite, 4'b0001);
        chk("t1_c2_byte", instr8, 8'h56);
        go(3);
        chk("t1_c5_irw", irwrite, 4'b1000);
        chk("t1_c5_byte", instr8, 8'hAB);
        go(1);
        chk("t1_c6_done", done, 1);
        chk("t1_c6_pc", pc, 8'h04);
        start = 1'b1; go(1); start = 1'b0;
        chk("b2b_addr", mem_addr, 8'h04);
        go(5);
        chk("b2b_done", done, 1);
        chk("b2b_pc", pc, 8'h08);

        // load has priority over start; then wrap-around fetch
        pc_load = 1'b1; pc_next = 8'hFE; start = 1'b1; go(1);
        pc_load = 1'b0; start = 1'b0;
        chk("load_busy", busy, 0);
        chk("load_pc", pc, 8'hFE);
        start = 1'b1; go(1); start = 1'b0;
        chk("wrap_addr0", mem_addr, 8'hFE);
        go(2);
        chk("wrap_addr2", mem_addr, 8'h00);
        go(3);
        chk("wrap_done", done, 1);
        chk("wrap_pc", pc, 8'h02);

        // three wait cycles on byte 1
        pc_load = 1'b1; pc_next = 8'h00; go(1); pc_load = 1'b0;
        start = 1'b1; go(1); start = 1'b0;
        go(1); ready = 1'b0;
        chk("wait_c2_irw", irwrite, 4'b0001);
        go(1);
        chk("wait_c3_addr", mem_addr, 8'h01);
        chk("wait_c3_irw", irwrite, 4'b0000);
        go(1);
        go(1); ready = 1'b1;
        chk("wait_c5_addr", mem_addr, 8'h01);
        chk("wait_c5_irw", irwrite, 4'b0000);
        go(1);
        chk("wait_c6_irw", irwrite, 4'b0010);
        chk("wait_c6_byte", instr8, 8'h34);
        go(3);
        chk("wait_c9_done", done, 1);
        chk("wait_c9_pc", pc, 8'h04);

        // start while in RD2 is ignored
        start = 1'b1; go(1); start = 1'b0;
        go(2); start = 1'b1; go(1); start = 1'b0;
        go(2);
        chk("rd2_done", done, 1);
        chk("rd2_pc", pc, 8'h08);
        go(1);
        chk("rd2_idle", busy, 0);

        // reset in RD2 abandons the word
        start = 1'b1; go(1); start = 1'b0;
        go(2); rst = 1'b1;
        go(1); rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_pc", pc, RESET_PC);
        chk("mrst_irw", irwrite, 0);
        chk("mrst_byte", instr8, 0);
        chk("mrst_done", done, 0);
        go(6);
        chk("mrst_pc_late", pc, RESET_PC);

`ifdef FETCH_TIMEOUT_EN
        ready = 1'b0;
        start = 1'b1; go(1); start = 1'b0;
        go(15);
        chk("to_c16_busy", busy, 1);
        go(1);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_pc", pc, RESET_PC);
        ready = 1'b1;
        go(2);
`endif

        go(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
